servo_pwm_capture: RTL and testbench
====================================

// Module: servo_pwm_capture
// PURPOSE
//  Receive side of the servo PWM link: measures the high time of a servo-style pulse on pwm_in
//  and recovers the 8-bit position code used by the servo pulse generators.
//  Mapping: width = MIN_WIDTH + pos*STEP, with 50 MHz clk and 20 ms frame.
//  Used for RC-receiver input and for loopback checks of our servo outputs.
// PARAMETERS
//  MIN_WIDTH    29200    high-time cycles for position 0
//  STEP         355      cycles per position LSB
//  MAX_WIDTH    120000   longest legal high time in cycles; longer pulses are errors
//  LOST_CYCLES  2000000  low time in cycles (40 ms) before signal_lost is asserted
//  FILTER_LEN   4        stable-sample count for the glitch filter (PWM_GLITCH_FILTER_EN only)
// PORTS
//  clk          in   1   system clock, 50 MHz
//  reset        in   1   asynchronous, active-high reset
//  pwm_in       in   1   asynchronous servo PWM input pin
//  position     out  8   last valid decoded position; held between pulses
//  pulse_width  out  21  last measured high time in cycles, valid or not
//  valid        out  1   1-cycle strobe when position/pulse_width update on a legal pulse
//  err_range    out  1   1-cycle strobe when a pulse is shorter than MIN_WIDTH or longer than MAX_WIDTH
//  signal_lost  out  1   level signal: no rising edge within LOST_CYCLES
// BEHAVIOUR
//  - Reset (async): position=0, pulse_width=0, valid=0, err_range=0, signal_lost=0, state=ARM.
//  - pwm_in passes through a 2-flop synchronizer, then a registered edge detect (rise/fall).
//  - States:
//    ARM: wait for synced input low, so a pulse in progress at reset is ignored -> WAIT_RISE.
//    WAIT_RISE: low counter runs; on rise -> HIGH, clear width and position sub-counters.
//    HIGH: width counter +1 per cycle.
//      Once width >= MIN_WIDTH, step sub-counter runs 0..STEP-1; each wrap increments pos_acc.
//      pos_acc saturates at 255. No divider is used.
//  - On fall in HIGH:
//    - pulse_width <= width.
//    - If MIN_WIDTH <= width <= MAX_WIDTH: position <= pos_acc = min(255, floor((width-MIN_WIDTH)/STEP)), valid=1.
//    - If width < MIN_WIDTH: err_range=1 and position is unchanged.
//    - Next state is WAIT_RISE.
//  - If width reaches MAX_WIDTH+1 while HIGH: abort, err_range=1, pulse_width <= MAX_WIDTH+1, -> ARM.
//  - Timing: valid/err_range assert exactly 3 clk cycles after the first clk edge that samples pwm_in low.
//    The 3 cycles are 2 sync + 1 edge register; outputs are registered.
//  - signal_lost sets when the low counter reaches LOST_CYCLES; it saturates there, with no wrap.
//    It clears on the same cycle that valid asserts.
//  - Simultaneous events:
//    - A rise edge in the same cycle the low counter hits LOST_CYCLES: the edge wins and signal_lost stays at its old value.
//    - A fall edge in the same cycle width hits MAX_WIDTH+1: the abort wins.
//  - valid and err_range are never high together.
//  - Reset mid-pulse discards the measurement; no strobe is produced.
//  - Counters are 21 bits wide. Width comparisons are unsigned. pos_acc is 8 bits with saturation.
// CONFIGURATION
//  `PWM_GLITCH_FILTER_EN defined:
//    - After the synchronizer, the filtered level changes only after FILTER_LEN consecutive equal samples.
//    - Pulses and gaps shorter than FILTER_LEN cycles are ignored.
//    - Strobe latency is 3+FILTER_LEN cycles. Width is still exact, because both edges are delayed equally.
//  Undefined: no filter. Every synchronized transition is an edge; latency is 3 cycles.
// STRUCTURE
//  - servo_pkg holds:
//    - constants CLK_HZ=50_000_000, FRAME_CYCLES=1_000_000, SERVO_MIN_WIDTH=29200, SERVO_STEP=355;
//    - typedef cap_state_t {ARM, WAIT_RISE, HIGH}.
//    The generator and capture sides share these.
//  - Sub-module pwm_in_sync contains the synchronizer, the optional filter and the edge detect.
//    Outputs: level, rise, fall.
//  - The top level holds the FSM, the counters and the output registers.
// TESTING
//  1. Reset, pwm_in low 1000 cycles, high 74641 cycles, low -> valid once, position=128, pulse_width=74641.
//  2. High 29201 -> position=0 valid. High 119726 -> position=255 valid.
//     High 120001 -> err_range at MAX_WIDTH+1, position unchanged.
//  3. High 10000 cycles -> err_range=1, valid=0, pulse_width=10000, position holds previous value.
//  4. Hold pwm_in low 2000000 cycles -> signal_lost=1.
//     Then a legal pulse of 29201 -> signal_lost=0 in the same cycle valid=1.
//  5. pwm_in high at reset release, falls after 50000 -> no strobe; the next legal pulse decodes correctly.
//     Also assert reset mid-pulse -> no strobe is produced.
//  6. With PWM_GLITCH_FILTER_EN, FILTER_LEN=4: a 2-cycle low glitch inside a 74641 pulse -> position=128, latency 7.
//     Without the macro, the same glitch splits the pulse into two measurements.

Source files
------------

// File: rtl/servo_pkg.sv
// ---------------------------------------------------------------------------
// servo_pkg
//   Constants and types shared by the servo pulse generators and the servo
//   PWM capture block.
//   Position mapping: high_time = SERVO_MIN_WIDTH + pos * SERVO_STEP cycles,
//   50 MHz clock, 20 ms frame.
// ---------------------------------------------------------------------------
package servo_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int FRAME_CYCLES    = CLK_HZ / 50;   // 20 ms frame
  localparam int SERVO_MIN_WIDTH = 29200;         // high time for position 0
  localparam int SERVO_STEP      = 355;           // cycles per position LSB

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// ---------------------------------------------------------------------------
// pwm_in_sync
//   Brings the asynchronous PWM pin into the clk domain and produces
//   registered edge strobes.
//   Optional macro PWM_GLITCH_FILTER_EN: the synchronized level only changes
//   after FILTER_LEN consecutive equal samples, so shorter pulses/gaps are
//   dropped. Both edges are delayed equally, so measured widths are exact.
// Ports
//   clk     in   system clock
//   reset   in   asynchronous active-high reset
//   pwm_in  in   raw PWM pin
//   level   out  synchronized (and filtered) level, aligned with rise/fall
//   rise    out  1-cycle strobe on a low->high transition
//   fall    out  1-cycle strobe on a high->low transition
// ---------------------------------------------------------------------------
module pwm_in_sync
`ifdef PWM_GLITCH_FILTER_EN
  #(parameter int FILTER_LEN = 4)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // The chain resets to 1 so the capture FSM only leaves ARM after a real
  // low has travelled through it; a pulse in progress at reset is ignored.
  logic [1:0] sync;
  logic       lvl;
  logic       level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], pwm_in};
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          filt;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the current filtered
  // level; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (sync[1] == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= sync[1];
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b1;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      level_q <= lvl;
      rise    <= lvl & ~level_q;
      fall    <= ~lvl & level_q;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// ---------------------------------------------------------------------------
// servo_pwm_capture
//   Measures the high time of a servo PWM pulse and recovers the 8-bit
//   position code: width = MIN_WIDTH + pos*STEP. The position is built by a
//   step sub-counter while the pulse is high, so no divider is needed.
//   Optional macro PWM_GLITCH_FILTER_EN enables the input glitch filter
//   (FILTER_LEN samples); strobe latency becomes 3+FILTER_LEN cycles.
// Ports
//   clk          in   system clock, 50 MHz
//   reset        in   asynchronous active-high reset
//   pwm_in       in   asynchronous servo PWM pin
//   position     out  last valid decoded position, held between pulses
//   pulse_width  out  last measured high time in cycles, valid or not
//   valid        out  1-cycle strobe on a legal pulse
//   err_range    out  1-cycle strobe on a too-short or too-long pulse
//   signal_lost  out  level, no rising edge within LOST_CYCLES
// ---------------------------------------------------------------------------
module servo_pwm_capture
  import servo_pkg::*;
#(
  parameter int MIN_WIDTH   = SERVO_MIN_WIDTH,
  parameter int STEP        = SERVO_STEP,
  parameter int MAX_WIDTH   = 120000,
  parameter int LOST_CYCLES = 2 * FRAME_CYCLES
`ifdef PWM_GLITCH_FILTER_EN
  , parameter int FILTER_LEN = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [7:0]  position,
  output logic [20:0] pulse_width,
  output logic        valid,
  output logic        err_range,
  output logic        signal_lost
);

  localparam logic [20:0] MIN_W     = 21'(MIN_WIDTH);
  localparam logic [20:0] ABORT_W   = 21'(MAX_WIDTH + 1);
  localparam logic [20:0] LOST_W    = 21'(LOST_CYCLES);
  localparam logic [20:0] LOST_LAST = 21'(LOST_CYCLES - 1);
  localparam logic [20:0] STEP_LAST = 21'(STEP - 1);

  logic level;
  logic rise;
  logic fall;

  pwm_in_sync
`ifdef PWM_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
  u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  cap_state_t  state;
  cap_state_t  state_next;
  logic [20:0] width;
  logic [20:0] step_cnt;
  logic [20:0] low_cnt;
  logic [7:0]  pos_acc;
  logic        pulse_done;
  logic        pulse_abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARM;
    end else begin
      state <= state_next;
    end
  end

  // The abort test comes first so a fall landing on the same cycle the width
  // reaches MAX_WIDTH+1 is treated as an over-range pulse.
  always_comb begin
    state_next  = state;
    pulse_done  = 1'b0;
    pulse_abort = 1'b0;
    case (state)
      ARM: begin
        if (!level) state_next = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) state_next = HIGH;
      end
      HIGH: begin
        if (width == ABORT_W) begin
          pulse_abort = 1'b1;
          state_next  = ARM;
        end else if (fall) begin
          pulse_done = 1'b1;
          state_next = WAIT_RISE;
        end
      end
      default: state_next = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width       <= '0;
      step_cnt    <= '0;
      low_cnt     <= '0;
      pos_acc     <= '0;
      position    <= '0;
      pulse_width <= '0;
      valid       <= 1'b0;
      err_range   <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      valid     <= 1'b0;
      err_range <= 1'b0;
      case (state)
        WAIT_RISE: begin
          if (rise) begin
            // The rise strobe marks the first high sample, so width starts
            // at 1 and equals the number of high samples at the fall.
            width    <= 21'd1;
            step_cnt <= '0;
            pos_acc  <= '0;
            low_cnt  <= '0;
          end else if (low_cnt != LOST_W) begin
            low_cnt <= low_cnt + 21'd1;
            if (low_cnt == LOST_LAST) signal_lost <= 1'b1;
          end
        end
        HIGH: begin
          if (pulse_abort) begin
            err_range   <= 1'b1;
            pulse_width <= ABORT_W;
          end else if (pulse_done) begin
            pulse_width <= width;
            if (width >= MIN_W) begin
              position    <= pos_acc;
              valid       <= 1'b1;
              signal_lost <= 1'b0;
            end else begin
              err_range <= 1'b1;
            end
          end else begin
            width <= width + 21'd1;
            // pos_acc tracks floor((width-MIN_WIDTH)/STEP) for the current
            // width value, saturating at 255.
            if (width >= MIN_W) begin
              if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                if (pos_acc != 8'hFF) pos_acc <= pos_acc + 8'd1;
              end else begin
                step_cnt <= step_cnt + 21'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_servo_pwm_capture
//   Directed bench with a scoreboard. The DUT runs with scaled timing
//   parameters (MIN_WIDTH=100, STEP=5, MAX_WIDTH=1400, LOST_CYCLES=3000)
//   so the whole run stays short; the mapping equations are unchanged.
//   Expected strobes carry the exact clk cycle at which they must appear.
// ---------------------------------------------------------------------------
module tb_servo_pwm_capture;

  localparam int MIN_WIDTH   = 100;
  localparam int STEP        = 5;
  localparam int MAX_WIDTH   = 1400;
  localparam int LOST_CYCLES = 3000;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_in;
  logic [7:0]  position;
  logic [20:0] pulse_width;
  logic        valid;
  logic        err_range;
  logic        signal_lost;

  servo_pwm_capture #(
    .MIN_WIDTH   (MIN_WIDTH),
    .STEP        (STEP),
    .MAX_WIDTH   (MAX_WIDTH),
    .LOST_CYCLES (LOST_CYCLES)
`ifdef PWM_GLITCH_FILTER_EN
    , .FILTER_LEN (4)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .position    (position),
    .pulse_width (pulse_width),
    .valid       (valid),
    .err_range   (err_range),
    .signal_lost (signal_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_valid;
    int pos;
    int pw;
    int cyc;
    bit chk_lost;
  } exp_t;

  typedef struct {
    int hi;
    int lo;
    bit is_valid;
    int pos;
    int pw;
    int tcy;   // cycles from rise to the sample that ends the measurement
  } row_t;

  exp_t exp_q[$];
  row_t rows[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  bit   prev_lost = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per strobe.
  always @(negedge clk) begin
    if (!reset && (valid || err_range)) begin
      exp_t e;
      txn++;
      $display("txn %0d: cycle=%0d valid=%0d err_range=%0d position=%0d pulse_width=%0d signal_lost=%0d",
               txn, cyc, valid, err_range, position, pulse_width, signal_lost);
      chk("strobe_exclusive", int'(valid && err_range), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind_valid", int'(valid), int'(e.is_valid));
        chk("position", int'(position), e.pos);
        chk("pulse_width", int'(pulse_width), e.pw);
        chk("strobe_cycle", cyc, e.cyc);
        if (e.is_valid) chk("lost_clear_on_valid", int'(signal_lost), 0);
        if (e.chk_lost) chk("lost_before_valid", int'(prev_lost), 1);
      end
    end
    prev_lost = signal_lost;
  end

  task automatic run_row(input row_t r, input bit chk_lost);
    exp_t e;
    @(negedge clk);
    e.is_valid = r.is_valid;
    e.pos      = r.pos;
    e.pw       = r.pw;
    e.cyc      = cyc + r.tcy + 1 + LAT;
    e.chk_lost = chk_lost;
    exp_q.push_back(e);
    pwm_in = 1'b1;
    repeat (r.hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (r.lo) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_position"}, int'(position), 0);
    chk({tag, "_pulse_width"}, int'(pulse_width), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_err_range"}, int'(err_range), 0);
    chk({tag, "_signal_lost"}, int'(signal_lost), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    row_t r;
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");
    repeat (50) @(negedge clk);

    // hi, lo, valid, position, pulse_width, tcy -- hand computed
    rows.push_back('{740,  200, 1'b1, 128, 740,  740});   // mid-scale
    rows.push_back('{101,  200, 1'b1, 0,   101,  101});   // just above min
    rows.push_back('{1375, 200, 1'b1, 255, 1375, 1375});  // full scale
    rows.push_back('{1401, 200, 1'b0, 255, 1401, 1401});  // fall at MAX+1, abort wins
    rows.push_back('{50,   200, 1'b0, 255, 50,   50});    // too short, position held
    rows.push_back('{100,  200, 1'b1, 0,   100,  100});   // exactly MIN_WIDTH
    rows.push_back('{99,   200, 1'b0, 0,   99,   99});    // one below MIN_WIDTH
    rows.push_back('{1400, 200, 1'b1, 255, 1400, 1400});  // MAX_WIDTH, saturated
    rows.push_back('{1700, 200, 1'b0, 255, 1401, 1401});  // aborted while high
    rows.push_back('{744,  200, 1'b1, 128, 744,  744});
    rows.push_back('{745,  200, 1'b1, 129, 745,  745});
    foreach (rows[i]) run_row(rows[i], 1'b0);

    // Loss of signal, then recovery on a legal pulse.
    repeat (2000) @(negedge clk);
    chk("signal_lost_early", int'(signal_lost), 0);
    repeat (1100) @(negedge clk);
    chk("signal_lost_set", int'(signal_lost), 1);
    r = '{101, 200, 1'b1, 0, 101, 101};
    run_row(r, 1'b1);
    chk("signal_lost_after", int'(signal_lost), 0);

    // Two-cycle low glitch inside a 740-cycle pulse.
    @(negedge clk);
    t0 = cyc;
`ifdef PWM_GLITCH_FILTER_EN
    exp_q.push_back('{1'b1, 128, 740, t0 + 740 + 1 + LAT, 1'b0});
`else
    exp_q.push_back('{1'b1, 40, 300, t0 + 300 + 1 + LAT, 1'b0});
    exp_q.push_back('{1'b1, 67, 438, t0 + 740 + 1 + LAT, 1'b0});
`endif
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    pwm_in = 1'b1;
    repeat (438) @(negedge clk);
    pwm_in = 1'b0;
    repeat (200) @(negedge clk);

    // Pulse already high at reset release: ignored.
    reset  = 1'b1;
    pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("reset_high");
    repeat (500) @(negedge clk);
    pwm_in = 1'b0;
    repeat (100) @(negedge clk);
    r = '{740, 200, 1'b1, 128, 740, 740};
    run_row(r, 1'b0);

    // Reset in the middle of a pulse: measurement discarded.
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("reset_mid");
    repeat (200) @(negedge clk);
    pwm_in = 1'b0;
    repeat (100) @(negedge clk);
    chk("no_strobe_after_reset", int'(pulse_width), 0);
    r = '{745, 200, 1'b1, 129, 745, 745};
    run_row(r, 1'b0);

    // Drain: every expected strobe must have been seen.
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("pending_expectations", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
